// File: rtl/sys_console_mc.sv
// sys_console_mc: multi-channel host console slave.
// The host issues session commands to the FIFO engine by writing CONN.
// The engine delivers message bytes into per-channel FIFOs, which the host reads back.
// The host can also read FIFO levels, overflow and drop flags, and a level interrupt.
module sys_console_mc #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] slave_address,
   input  logic              slave_read,
   output logic [DATA_W-1:0] slave_readdata,
   input  logic              slave_write,
   input  logic [DATA_W-1:0] slave_writedata,
   output logic              cmd_valid,
   output logic [DATA_W-1:0] cmd_data,
   output logic [CH_W-1:0]   cmd_chan,
   input  logic              cmd_ready,
   input  logic              msg_valid,
   input  logic [DATA_W-1:0] msg_data,
   input  logic [CH_W-1:0]   msg_chan,
   output logic              irq
);

   // FIFO index width and pointer width; the extra pointer MSB separates full from empty
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_RDATA = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CHSEL = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_LEVEL = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_CONN  = ADDR_W'(6);

   // Per-channel FIFO storage and state
   logic [DATA_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q [NUM_CH];
   logic [PW-1:0]     rd_ptr_q [NUM_CH];
   logic [PW-1:0]     level_c  [NUM_CH];
   logic [NUM_CH-1:0] ovf_q;

   logic [NUM_CH-1:0] empty_c;
   logic [NUM_CH-1:0] full_c;
   logic [NUM_CH-1:0] msg_hit_c;
   logic [NUM_CH-1:0] pop_c;
   logic [NUM_CH-1:0] push_c;
   logic [NUM_CH-1:0] ovf_set_c;
   logic [NUM_CH-1:0] ovf_clr_c;

   // Host-visible registers
   logic [CH_W-1:0]   chsel_q;
   logic [1:0]        irqen_q;
   logic              cmd_drop_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_c;

   // Command and interrupt registers
   logic              cmd_valid_q;
   logic [DATA_W-1:0] cmd_data_q;
   logic [CH_W-1:0]   cmd_chan_q;
   logic              irq_q;
   logic              irq_d;

   // Bus access decode; a write in the same cycle as a read wins
   logic rd_acc_c;
   logic wr_acc_c;
   logic conn_c;
   logic accept_c;
   logic chsel_ok_c;

   assign rd_acc_c   = slave_read && !slave_write;
   assign wr_acc_c   = slave_write;
   assign conn_c     = wr_acc_c && (slave_address == A_CONN);
   assign accept_c   = cmd_valid_q && cmd_ready;
   assign chsel_ok_c = (slave_writedata < DATA_W'(NUM_CH));

   // Per-channel status, push/pop qualification and overflow events
   always_comb begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         level_c[c]   = wr_ptr_q[c] - rd_ptr_q[c];
         empty_c[c]   = (wr_ptr_q[c] == rd_ptr_q[c]);
         full_c[c]    = (wr_ptr_q[c] == {~rd_ptr_q[c][PW-1], rd_ptr_q[c][AW-1:0]});
         msg_hit_c[c] = msg_valid && (msg_chan == CH_W'(c));
         pop_c[c]     = rd_acc_c && (slave_address == A_RDATA)
                        && (chsel_q == CH_W'(c)) && !empty_c[c];
         push_c[c]    = msg_hit_c[c] && (!full_c[c] || pop_c[c]);
         ovf_set_c[c] = msg_hit_c[c] && full_c[c] && !pop_c[c];
         ovf_clr_c[c] = wr_acc_c && (slave_address == A_CLR) && slave_writedata[0]
                        && (chsel_q == CH_W'(c));
      end
   end

   // FIFO pointers and sticky overflow flags; a new overflow takes priority over a clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            if (push_c[c]) begin
               wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
            end
            if (pop_c[c]) begin
               rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
            end
            if (ovf_set_c[c]) begin
               ovf_q[c] <= 1'b1;
            end else if (ovf_clr_c[c]) begin
               ovf_q[c] <= 1'b0;
            end
         end
      end
   end

   // FIFO storage; contents are meaningless after reset since the pointers restart
   always_ff @(posedge clk) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (push_c[c]) begin
            mem_q[c][wr_ptr_q[c][AW-1:0]] <= msg_data;
         end
      end
   end

   // Read-data mux, built from the state seen before this cycle's edge
   always_comb begin
      rdata_c = '0;
      case (slave_address)
         A_STAT:  rdata_c = DATA_W'({irq_q, cmd_drop_q, ovf_q[chsel_q], cmd_valid_q,
                                     full_c[chsel_q], ~empty_c[chsel_q]});
         A_RDATA: begin
            if (!empty_c[chsel_q]) begin
               rdata_c = mem_q[chsel_q][rd_ptr_q[chsel_q][AW-1:0]];
            end
         end
         A_CHSEL: rdata_c = DATA_W'(chsel_q);
         A_LEVEL: rdata_c = DATA_W'(level_c[chsel_q]);
         A_IRQEN: rdata_c = DATA_W'(irqen_q);
         default: rdata_c = '0;
      endcase
   end

   // Host registers: read-data hold, channel select, irq enables, command drop flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q    <= '0;
         chsel_q    <= '0;
         irqen_q    <= '0;
         cmd_drop_q <= 1'b0;
      end else begin
         if (rd_acc_c) begin
            rdata_q <= rdata_c;
         end
         if (wr_acc_c && (slave_address == A_CHSEL) && chsel_ok_c) begin
            chsel_q <= CH_W'(slave_writedata);
         end
         if (wr_acc_c && (slave_address == A_IRQEN)) begin
            irqen_q <= slave_writedata[1:0];
         end
         if (conn_c && cmd_valid_q && !accept_c) begin
            cmd_drop_q <= 1'b1;
         end else if (wr_acc_c && (slave_address == A_CLR) && slave_writedata[1]) begin
            cmd_drop_q <= 1'b0;
         end
      end
   end

   // Command hand-off; a CONN write in the same cycle as the accept is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         cmd_chan_q  <= '0;
      end else begin
         if (conn_c && (!cmd_valid_q || accept_c)) begin
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= slave_writedata;
            cmd_chan_q  <= chsel_q;
         end else if (accept_c) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
         end
      end
   end

   // Interrupt condition, evaluated on the current state so irq lags by one cycle
   assign irq_d = (irqen_q[0] && !empty_c[chsel_q]) || (irqen_q[1] && (|ovf_q));

   // Interrupt register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign slave_readdata = rdata_q;
   assign cmd_valid      = cmd_valid_q;
   assign cmd_data       = cmd_data_q;
   assign cmd_chan       = cmd_chan_q;
   assign irq            = irq_q;

endmodule
